// File: rtl/tx_arbiter.sv
// Round-robin arbiter that feeds one or two payload bytes from three requesters to a UART TX.
// Optional tx_done watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  two_byte,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [2:0]  ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [7:0]  lo_q, lo_d;
  logic        lo_pend_q, lo_pend_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  rr_idx, cand;
  logic        rr_hit;
  logic [15:0] sel_data;
  logic [1:0]  ptr_next;
  logic        timeout;

  // First requesting index at or after the pointer, wrapping mod 3.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = ptr_q;
    cand   = ptr_q;
    for (int i = 0; i < 3; i++) begin
      cand = 2'((32'(ptr_q) + 32'(i)) % 32'd3);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    case (rr_idx)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      default: sel_data = data2;
    endcase
  end

  assign ptr_next = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        to_q;

  // Fires on the last WAIT cycle so ack lands TIMEOUT_CYCLES after trmt.
  assign timeout = (32'(cnt_q) + 32'd2 >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_q == StLoad) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (state_q == StIdle) begin
        to_q <= 1'b0;
      end else if (state_q == StWait && !tx_done && timeout) begin
        to_q <= 1'b1;
      end
    end
  end

  assign err = (state_q == StAck) && to_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    lo_d      = lo_q;
    lo_pend_d = lo_pend_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (rr_hit) begin
          gnt_d     = rr_idx;
          lo_d      = sel_data[7:0];
          lo_pend_d = two_byte[rr_idx];
          tx_data_d = two_byte[rr_idx] ? sel_data[15:8] : sel_data[7:0];
          state_d   = StLoad;
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        if (tx_done) begin
          if (lo_pend_q) begin
            lo_pend_d = 1'b0;
            tx_data_d = lo_q;
            state_d   = StLoad;
          end else begin
            ptr_d   = ptr_next;
            state_d = StAck;
          end
        end else if (timeout) begin
          lo_pend_d = 1'b0;
          ptr_d     = ptr_next;
          state_d   = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      gnt_q     <= 2'd0;
      lo_q      <= 8'h00;
      lo_pend_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      lo_q      <= lo_d;
      lo_pend_q <= lo_pend_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign trmt    = (state_q == StLoad);
  assign tx_data = tx_data_q;
  assign ack     = (state_q == StAck) ? (3'b001 << gnt_q) : 3'b000;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter (default build, watchdog disabled).
// Inputs change and outputs are sampled on the falling edge.
module tb_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  two_byte;
  logic [15:0] data0, data1, data2;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [2:0]  ack;
  logic        err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .two_byte (two_byte),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .ack      (ack),
    .err      (err),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait up to max_cyc falling edges for trmt; an expired bound shows as a failed check.
  task automatic wait_trmt(input string tag, input int max_cyc);
    int n = 0;
    while (trmt !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, {15'd0, trmt}, 16'd1);
  endtask

  // Idle n-1 cycles in WAIT (flagging any stray activity), then pulse tx_done for one cycle.
  task automatic done_after(input int n, output logic bad);
    bad = 1'b0;
    repeat (n - 1) begin
      step();
      if (busy !== 1'b1 || trmt !== 1'b0 || ack !== 3'b000) bad = 1'b1;
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  logic       bad;
  int         order [4] = '{0, 1, 2, 0};
  logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    rst = 1'b1; req = 3'b000; two_byte = 3'b000; tx_done = 1'b0;
    data0 = 16'h0000; data1 = 16'h0000; data2 = 16'h0000;
    step(); step();
    rst = 1'b0;
    check("rst_trmt", {15'd0, trmt}, 16'd0);
    check("rst_tx_data", {8'd0, tx_data}, 16'h0000);
    check("rst_ack", {13'd0, ack}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);

    // tx_done while idle is ignored.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    check("idle_done_busy", {15'd0, busy}, 16'd0);
    check("idle_done_ack", {13'd0, ack}, 16'd0);

    // Two-byte transfer from requester 0; payload changes after grant must not leak in.
    data0 = 16'hA55A; two_byte = 3'b001; req = 3'b001;
    step();
    check("w_trmt_latency", {15'd0, trmt}, 16'd1);
    check("w_hi_byte", {8'd0, tx_data}, 16'h00A5);
    check("w_busy", {15'd0, busy}, 16'd1);
    data0 = 16'hFFFF;
    step(); step(); step();
    check("w_trmt_one_cycle", {15'd0, trmt}, 16'd0);
    check("w_tx_data_hold", {8'd0, tx_data}, 16'h00A5);
    done_after(7, bad);
    check("w_wait1_quiet", {15'd0, bad}, 16'd0);
    check("w_lo_trmt", {15'd0, trmt}, 16'd1);
    check("w_lo_byte", {8'd0, tx_data}, 16'h005A);
    done_after(10, bad);
    check("w_wait2_quiet", {15'd0, bad}, 16'd0);
    check("w_ack", {13'd0, ack}, 16'h0001);
    check("w_ack_busy", {15'd0, busy}, 16'd1);
    check("w_err", {15'd0, err}, 16'd0);
    req = 3'b000;
    step();
    check("w_ack_pulse", {13'd0, ack}, 16'd0);
    check("w_idle_busy", {15'd0, busy}, 16'd0);

    // Single-byte transfer from requester 1 sends only the low byte.
    data1 = 16'h1234; two_byte = 3'b000; req = 3'b010;
    wait_trmt("b_trmt", 4);
    check("b_lo_byte", {8'd0, tx_data}, 16'h0034);
    done_after(3, bad);
    check("b_quiet", {15'd0, bad}, 16'd0);
    check("b_ack", {13'd0, ack}, 16'h0002);
    check("b_no_second_trmt", {15'd0, trmt}, 16'd0);
    req = 3'b000;
    step();

    // All three requesting after reset: order 0,1,2,0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    data0 = 16'h0011; data1 = 16'h0022; data2 = 16'h0033; two_byte = 3'b000; req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_trmt($sformatf("rr%0d_trmt", k), 6);
      check($sformatf("rr%0d_byte", k), {8'd0, tx_data}, {8'd0, bytes[order[k]]});
      done_after(2, bad);
      check($sformatf("rr%0d_ack", k), {13'd0, ack}, 16'(3'b001 << order[k]));
    end
    req = 3'b000;
    step();

    // Reset mid-transfer: abandoned without ack, pointer back to 0.
    data1 = 16'hBEEF; two_byte = 3'b010; req = 3'b010;
    wait_trmt("r_trmt", 4);
    check("r_hi_byte", {8'd0, tx_data}, 16'h00BE);
    step(); step();
    rst = 1'b1; req = 3'b000;
    step();
    rst = 1'b0;
    check("r_busy", {15'd0, busy}, 16'd0);
    check("r_tx_data", {8'd0, tx_data}, 16'h0000);
    bad = 1'b0;
    repeat (4) begin
      step();
      if (ack !== 3'b000 || busy !== 1'b0) bad = 1'b1;
    end
    check("r_no_ack", {15'd0, bad}, 16'd0);
    data0 = 16'h0077; data1 = 16'h0088; two_byte = 3'b000; req = 3'b011;
    wait_trmt("r_next_trmt", 4);
    check("r_next_byte", {8'd0, tx_data}, 16'h0077);
    done_after(2, bad);
    check("r_next_ack", {13'd0, ack}, 16'h0001);
    req = 3'b000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, tx_done watchdog limit in clk cycles.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port req  input  3  per-requester transmit request; held high until that requester's ack.
REQ-005 SHALL have port two_byte  input  3  per-requester flag: 1 = send 16-bit word, 0 = send low byte only.
REQ-006 SHALL have port data0/data1/data2  input  16 each  per-requester payload.
REQ-007 SHALL have port trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-008 SHALL have port tx_data  output  8  byte presented to the transmitter; valid while trmt is high.
REQ-009 SHALL have port tx_done  input  1  transmitter byte-complete pulse.
REQ-010 SHALL have port ack  output  3  one-hot, one-cycle completion pulse to the serviced requester.
REQ-011 SHALL have port err  output  1  one-cycle timeout pulse, coincident with ack.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD, WAIT, ACK.
REQ-014 IDLE: if any req bit is high, SHALL grant one requester by round-robin, latch its payload and two_byte flag, and go to LOAD; otherwise SHALL stay in IDLE.
REQ-015 Round-robin SHALL start searching at the pointer index and wrap mod 3; pointer SHALL become (granted+1) mod 3 on entry to ACK.
REQ-016 LOAD: SHALL assert trmt for exactly one cycle with tx_data = high byte if a high byte is still pending, else low byte, then go to WAIT.
REQ-017 WAIT: on tx_done, SHALL go to LOAD if the low byte remains, else to ACK; tx_done in any other state SHALL be ignored.
REQ-018 ACK: SHALL assert ack[granted] for exactly one cycle and return to IDLE, where req is sampled again on the following cycle.
REQ-019 Latency: req sampled high in IDLE at cycle n SHALL produce trmt at cycle n+1.
REQ-020 Byte order: two_byte=1 SHALL send data[15:8] then data[7:0]; two_byte=0 SHALL send data[7:0] only.
REQ-021 Changes on the granted requester's req or data after grant SHALL NOT affect the transfer in progress.
REQ-022 Simultaneous requests SHALL be serviced one at a time; the losing requester is served in a later IDLE.
REQ-023 tx_data SHALL hold its last value when trmt is low.

Reset
REQ-024 When rst is high at a clock edge, SHALL go to IDLE, set pointer=0, trmt=0, tx_data=8'h00, ack=3'b000, err=0, busy=0.
REQ-025 Reset during a transfer SHALL abandon it without ack.

Configuration
REQ-026 Macro TX_ARB_TIMEOUT_EN defined: SHALL count cycles in WAIT, clearing the count on entry to WAIT.
REQ-027 With TX_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without tx_done SHALL skip remaining bytes, go to ACK, and pulse err with ack.
REQ-028 Macro TX_ARB_TIMEOUT_EN undefined: SHALL implement no counter, tie err to 0, and wait in WAIT indefinitely.

Verification
REQ-029 req=3'b001, two_byte[0]=1, data0=16'hA55A, tx_done 10 cycles after each trmt -> trmt with tx_data 8'hA5, then 8'h5A, then ack=3'b001; busy high throughout.
REQ-030 req=3'b111 held after reset with all acks honoured -> service order 0,1,2,0.
REQ-031 req=3'b010, two_byte[1]=0, data1=16'h1234 -> exactly one trmt with tx_data 8'h34, then ack=3'b010.
REQ-032 rst pulsed in WAIT of a two-byte transfer -> no ack, busy=0, next grant goes to requester 0.
REQ-033 TX_ARB_TIMEOUT_EN defined with TIMEOUT_CYCLES=20, tx_done never asserted -> ack and err both pulse 20 cycles after trmt.
REQ-034 tx_done pulsed while in IDLE -> no state change and no ack.
